// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bus shared by the UART transmit arbiter.
// The slave side is the arbiter; the master side is the environment
// (requesters plus the byte transmitter that reports busy).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_enable;
  logic                 uart_tx_busy;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_data, uart_tx_enable
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_data, uart_tx_enable
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ
// requesters. One byte in flight at a time; enable is a level whose rising
// edge starts the transmitter, so a guard gap keeps it low between bytes.
// A requester keeps the grant until it sends a byte marked last.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int GUARD_CYCLES   = 4,
  parameter int LAUNCH_TIMEOUT = 16
) (
  input  logic                 uart_tx_clk,
  input  logic                 reset,
  uart_tx_arbiter_if.slave     bus,
  input  logic                 err_clr,
  output logic [IDX_W-1:0]     owner,
  output logic                 lock_active,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // One counter serves both the launch timeout and the guard gap.
  localparam int CNT_MAX = (LAUNCH_TIMEOUT > GUARD_CYCLES) ? LAUNCH_TIMEOUT : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] OWNER_RST   = IDX_W'(NUM_REQ - 1);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [7:0]         data_r, data_s;
  logic [IDX_W-1:0]   owner_r, owner_s;
  logic               lock_r, lock_s;
  logic               enable_r, enable_s;
  logic               err_r, err_s;

  logic               found_s;
  logic [IDX_W-1:0]   sel_s;
  logic [7:0]         sel_byte_s;
  logic [NUM_REQ-1:0] ready_s;

  // Requester index reached by stepping 'step' places past 'base', wrapping.
  function automatic logic [IDX_W-1:0] wrap_next(input logic [IDX_W-1:0] base, input int step);
    int sum_v;
    sum_v = int'(base) + step;
    return IDX_W'(sum_v % NUM_REQ);
  endfunction

  // Arbitration: locked owner only, else first valid after the last owner.
  always_comb begin : arb_search
    logic [IDX_W-1:0] cand_v;
    found_s = 1'b0;
    sel_s   = {IDX_W{1'b0}};
    cand_v  = {IDX_W{1'b0}};
    if (lock_r) begin
      found_s = bus.req_valid[owner_r];
      sel_s   = owner_r;
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand_v = wrap_next(owner_r, i);
        if (!found_s && bus.req_valid[cand_v]) begin
          found_s = 1'b1;
          sel_s   = cand_v;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Byte of the selected requester.
  always_comb begin
    sel_byte_s = bus.req_data[int'(sel_s)*8 +: 8];
  end

  // One-hot accept strobe, only while idle.
  always_comb begin
    ready_s = {NUM_REQ{1'b0}};
    if ((state_r == IDLE) && found_s) begin
      ready_s[sel_s] = 1'b1;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
  end

  // Next-state and next-output logic for the transmit handshake.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    data_s   = data_r;
    owner_s  = owner_r;
    lock_s   = lock_r;
    enable_s = enable_r;
    // Clear first so a timeout in the same cycle still leaves the flag set.
    if (err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end

    case (state_r)
      IDLE: begin
        if (found_s) begin
          data_s   = sel_byte_s;
          owner_s  = sel_s;
          lock_s   = ~bus.req_last[sel_s];
          enable_s = 1'b1;
          cnt_s    = {CNT_W{1'b0}};
          state_s  = LAUNCH;
        end else begin
          enable_s = 1'b0;
        end
      end
      LAUNCH: begin
        if (bus.uart_tx_busy) begin
          enable_s = 1'b0;
          cnt_s    = {CNT_W{1'b0}};
          state_s  = WAIT_DONE;
        end else if (cnt_r == LAUNCH_LAST) begin
          // Transmitter never answered: drop the byte, keep the lock as set.
          enable_s = 1'b0;
          err_s    = 1'b1;
          cnt_s    = {CNT_W{1'b0}};
          state_s  = GAP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = GAP;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      GAP: begin
        // Covers the stop-bit tail and keeps enable low long enough to
        // make the next rising edge visible.
        if (cnt_r == GUARD_LAST) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        enable_s = 1'b0;
        cnt_s    = {CNT_W{1'b0}};
        state_s  = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge uart_tx_clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      data_r   <= 8'h00;
      owner_r  <= OWNER_RST;
      lock_r   <= 1'b0;
      enable_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      data_r   <= data_s;
      owner_r  <= owner_s;
      lock_r   <= lock_s;
      enable_r <= enable_s;
      err_r    <= err_s;
    end
  end

  assign bus.req_ready      = ready_s;
  assign bus.uart_tx_data   = data_r;
  assign bus.uart_tx_enable = enable_r;
  assign owner              = owner_r;
  assign lock_active        = lock_r;
  assign timeout_err        = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for arbitration and
// locking, plus hand-written sequences for timing, timeout and reset cases.
module tb_uart_tx_arbiter;
  localparam int NREQ   = 4;
  localparam int GUARD  = 4;
  localparam int TOUT   = 16;
  localparam int GUARD2 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_clr = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) ifm();
  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) ifg();

  logic [1:0] owner_m, owner_g;
  logic lock_m, lock_g, err_m, err_g;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .IDX_W(2), .GUARD_CYCLES(GUARD), .LAUNCH_TIMEOUT(TOUT)) u_dut (
    .uart_tx_clk(clk), .reset(reset), .bus(ifm.slave), .err_clr(err_clr),
    .owner(owner_m), .lock_active(lock_m), .timeout_err(err_m));

  uart_tx_arbiter #(.NUM_REQ(NREQ), .IDX_W(2), .GUARD_CYCLES(GUARD2), .LAUNCH_TIMEOUT(TOUT)) u_dut_g2 (
    .uart_tx_clk(clk), .reset(reset), .bus(ifg.slave), .err_clr(err_clr),
    .owner(owner_g), .lock_active(lock_g), .timeout_err(err_g));

  // Transmitter model: busy rises busy_dly cycles after an enable rise, lasts busy_len.
  logic busy_en = 1'b1;
  int   busy_dly = 3;
  int   busy_len = 100;
  logic tb_busy = 1'b0;
  logic en_prev = 1'b0;
  logic pend = 1'b0;
  int   dcnt = 0;
  int   lcnt = 0;
  logic g2_busy = 1'b0;
  assign ifm.uart_tx_busy = tb_busy;
  assign ifg.uart_tx_busy = g2_busy;

  always @(negedge clk) begin
    en_prev <= ifm.uart_tx_enable;
    if (busy_en && ifm.uart_tx_enable && !en_prev) begin
      pend <= 1'b1;
      dcnt <= 1;
    end else if (pend) begin
      if (dcnt >= busy_dly) begin
        pend <= 1'b0;
        tb_busy <= 1'b1;
        lcnt <= 1;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else if (tb_busy) begin
      if (lcnt >= busy_len) tb_busy <= 1'b0;
      else lcnt <= lcnt + 1;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready_m(input string nm);
    int cyc;
    cyc = 0;
    #1;
    while (ifm.req_ready == 4'b0000 && cyc < 400) begin
      tick();
      cyc++;
    end
    check({nm, "_wait"}, 32'(cyc < 400), 32'd1);
  endtask

  task automatic wait_idle_m(input string nm);
    int w;
    w = 0;
    while (!tb_busy && w < 50) begin tick(); w++; end
    while (tb_busy && w < 450) begin tick(); w++; end
    check({nm, "_idle_wait"}, 32'(w < 450), 32'd1);
    repeat (GUARD + 2) tick();
  endtask

  typedef struct packed {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [1:0]  exp_sel;
    logic [7:0]  exp_data;
    logic        exp_lock;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int en_hi, pulses, w, g, n, lo, cnt;
    logic [3:0] exp_rdy;

    // Round robin from reset (owner=3), then a 3-byte locked packet from req1.
    vecs[0]  = '{valid:4'hF, last:4'hF, data:32'hA3A2A1A0, exp_sel:2'd0, exp_data:8'hA0, exp_lock:1'b0};
    vecs[1]  = '{valid:4'hF, last:4'hF, data:32'hA3A2A1A0, exp_sel:2'd1, exp_data:8'hA1, exp_lock:1'b0};
    vecs[2]  = '{valid:4'hF, last:4'hF, data:32'hA3A2A1A0, exp_sel:2'd2, exp_data:8'hA2, exp_lock:1'b0};
    vecs[3]  = '{valid:4'hF, last:4'hF, data:32'hA3A2A1A0, exp_sel:2'd3, exp_data:8'hA3, exp_lock:1'b0};
    vecs[4]  = '{valid:4'hF, last:4'hF, data:32'hA3A2A1A0, exp_sel:2'd0, exp_data:8'hA0, exp_lock:1'b0};
    vecs[5]  = '{valid:4'h7, last:4'h5, data:32'h00C2B1C0, exp_sel:2'd1, exp_data:8'hB1, exp_lock:1'b1};
    vecs[6]  = '{valid:4'h7, last:4'h5, data:32'h00C2B2C0, exp_sel:2'd1, exp_data:8'hB2, exp_lock:1'b1};
    vecs[7]  = '{valid:4'h7, last:4'h7, data:32'h00C2B3C0, exp_sel:2'd1, exp_data:8'hB3, exp_lock:1'b0};
    vecs[8]  = '{valid:4'h5, last:4'h5, data:32'h00C200C0, exp_sel:2'd2, exp_data:8'hC2, exp_lock:1'b0};
    vecs[9]  = '{valid:4'h5, last:4'h5, data:32'h00C200C0, exp_sel:2'd0, exp_data:8'hC0, exp_lock:1'b0};
    vecs[10] = '{valid:4'h7, last:4'h5, data:32'h00C2D1C0, exp_sel:2'd1, exp_data:8'hD1, exp_lock:1'b1};

    ifm.req_valid = 4'h0; ifm.req_last = 4'h0; ifm.req_data = 32'h0;
    ifg.req_valid = 4'h0; ifg.req_last = 4'h0; ifg.req_data = 32'h0;

    // Reset values.
    reset = 1'b1;
    tick(); tick();
    check("rst_enable", 32'(ifm.uart_tx_enable), 32'd0);
    check("rst_data", 32'(ifm.uart_tx_data), 32'h0);
    check("rst_owner", 32'(owner_m), 32'd3);
    check("rst_lock", 32'(lock_m), 32'd0);
    check("rst_err", 32'(err_m), 32'd0);
    check("rst_err_g2", 32'(err_g), 32'd0);
    check("rst_ready", 32'(ifm.req_ready), 32'h0);
    reset = 1'b0;
    tick();

    // Single byte; valid left high to observe the guard before the next accept.
    busy_len = 100;
    ifm.req_valid = 4'b0001; ifm.req_last = 4'b0001; ifm.req_data = 32'h00000055;
    wait_ready_m("sb");
    check("sb_ready", 32'(ifm.req_ready), 32'h1);
    pulses = 1;
    tick();
    check("sb_data", 32'(ifm.uart_tx_data), 32'h55);
    check("sb_owner", 32'(owner_m), 32'd0);
    check("sb_lock", 32'(lock_m), 32'd0);
    en_hi = 0;
    while (ifm.uart_tx_enable && en_hi < 200) begin
      en_hi++;
      if (ifm.req_ready != 4'b0000) pulses++;
      tick();
    end
    check("sb_enable_cycles", 32'(en_hi), 32'd4);
    w = 0;
    while (tb_busy && w < 400) begin
      if (ifm.req_ready != 4'b0000) pulses++;
      tick();
      w++;
    end
    check("sb_busy_wait", 32'(w < 400), 32'd1);
    check("sb_ready_pulses", 32'(pulses), 32'd1);
    // Busy seen low in WAIT_DONE, GUARD cycles of GAP, then IDLE accepts.
    g = 0;
    do begin tick(); g++; end while (ifm.req_ready == 4'b0000 && g < 50);
    check("sb_busy_to_accept", 32'(g), 32'(GUARD + 1));
    check("sb_data_stable", 32'(ifm.uart_tx_data), 32'h55);
    ifm.req_valid = 4'b0000;
    tick();

    // Restart from reset so the round robin begins at requester 0.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    busy_len = 20;
    for (int k = 0; k < 11; k++) begin
      ifm.req_valid = vecs[k].valid;
      ifm.req_last  = vecs[k].last;
      ifm.req_data  = vecs[k].data;
      wait_ready_m($sformatf("v%0d", k));
      exp_rdy = 4'b0001 << vecs[k].exp_sel;
      check($sformatf("v%0d_ready", k), 32'(ifm.req_ready), 32'(exp_rdy));
      tick();
      check($sformatf("v%0d_data", k), 32'(ifm.uart_tx_data), 32'(vecs[k].exp_data));
      check($sformatf("v%0d_owner", k), 32'(owner_m), 32'(vecs[k].exp_sel));
      check($sformatf("v%0d_lock", k), 32'(lock_m), 32'(vecs[k].exp_lock));
      check($sformatf("v%0d_enable", k), 32'(ifm.uart_tx_enable), 32'd1);
      check($sformatf("v%0d_ready_busy", k), 32'(ifm.req_ready), 32'h0);
      ifm.req_valid = 4'h0;
    end

    // Locked requester 1 drops valid: others must not be served.
    ifm.req_valid = 4'b0101; ifm.req_last = 4'b0101;
    wait_idle_m("lk");
    cnt = 0;
    repeat (20) begin
      if (ifm.req_ready != 4'b0000) cnt++;
      tick();
    end
    check("lk_no_grant", 32'(cnt), 32'd0);
    check("lk_lock_held", 32'(lock_m), 32'd1);
    check("lk_owner", 32'(owner_m), 32'd1);

    // Reset during WAIT_DONE.
    busy_len = 100;
    ifm.req_valid = 4'b0010; ifm.req_last = 4'b0000; ifm.req_data = 32'h00006600;
    wait_ready_m("rm");
    check("rm_ready", 32'(ifm.req_ready), 32'h2);
    tick();
    ifm.req_valid = 4'h0;
    w = 0;
    while (!(tb_busy && !ifm.uart_tx_enable) && w < 50) begin tick(); w++; end
    check("rm_wait_done_wait", 32'(w < 50), 32'd1);
    reset = 1'b1;
    tick();
    check("rm_enable", 32'(ifm.uart_tx_enable), 32'd0);
    check("rm_owner", 32'(owner_m), 32'd3);
    check("rm_lock", 32'(lock_m), 32'd0);
    check("rm_ready", 32'(ifm.req_ready), 32'h0);
    reset = 1'b0;
    cnt = 0;
    repeat (3) begin
      tick();
      if (ifm.req_ready != 4'b0000) cnt++;
    end
    check("rm_ready_quiet", 32'(cnt), 32'd0);
    // The abandoned frame keeps busy high; an idle accept still happens.
    ifm.req_valid = 4'b0100; ifm.req_last = 4'b0100; ifm.req_data = 32'h00770000;
    wait_ready_m("bi");
    check("bi_ready", 32'(ifm.req_ready), 32'h4);
    tick();
    check("bi_enable", 32'(ifm.uart_tx_enable), 32'd1);
    check("bi_data", 32'(ifm.uart_tx_data), 32'h77);
    check("bi_owner", 32'(owner_m), 32'd2);
    tick();
    check("bi_enable_drop", 32'(ifm.uart_tx_enable), 32'd0);
    ifm.req_valid = 4'h0;
    wait_idle_m("bi");

    // Launch timeout with the transmitter never answering.
    busy_en = 1'b0;
    ifm.req_valid = 4'b0001; ifm.req_last = 4'b0001; ifm.req_data = 32'h00000011;
    wait_ready_m("to");
    check("to_ready", 32'(ifm.req_ready), 32'h1);
    tick();
    en_hi = 0;
    while (ifm.uart_tx_enable && en_hi < 100) begin en_hi++; tick(); end
    check("to_enable_cycles", 32'(en_hi), 32'(TOUT));
    check("to_err_set", 32'(err_m), 32'd1);
    g = 0;
    while (ifm.req_ready == 4'b0000 && g < 50) begin g++; tick(); end
    check("to_gap_cycles", 32'(g), 32'(GUARD));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ifm.req_valid = 4'h0;
    check("to_err_cleared", 32'(err_m), 32'd0);
    check("to_second_enable", 32'(ifm.uart_tx_enable), 32'd1);
    n = 1;
    while (n < TOUT) begin tick(); n++; end
    check("to_enable_last", 32'(ifm.uart_tx_enable), 32'd1);
    // Clear in the same cycle as the timeout: the flag must stay set.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr_collide", 32'(err_m), 32'd1);
    check("to_second_enable_off", 32'(ifm.uart_tx_enable), 32'd0);
    repeat (GUARD + 2) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr_final", 32'(err_m), 32'd0);

    // Guard timing on the GUARD_CYCLES=2 instance with back-to-back bytes.
    ifg.req_valid = 4'b0001; ifg.req_last = 4'b0001; ifg.req_data = 32'h0000003C;
    #1;
    check("g2_ready", 32'(ifg.req_ready), 32'h1);
    tick();
    check("g2_enable", 32'(ifg.uart_tx_enable), 32'd1);
    check("g2_data", 32'(ifg.uart_tx_data), 32'h3C);
    g2_busy = 1'b1;
    repeat (5) tick();
    g2_busy = 1'b0;
    tick();
    lo = 0;
    while (!ifg.uart_tx_enable && lo < 50) begin lo++; tick(); end
    // GAP for 2 cycles, one IDLE accept cycle, then enable rises.
    check("g2_low_cycles", 32'(lo), 32'(GUARD2 + 1));
    check("g2_low_min", 32'(lo >= 2), 32'd1);
    check("g2_owner", 32'(owner_g), 32'd0);
    check("g2_lock", 32'(lock_g), 32'd0);
    ifg.req_valid = 4'h0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
